// File: rtl/msdap_pkg.sv
// rtl/msdap_pkg.sv - shared state encoding and default sizes for the MSDAP controller
package msdap_pkg;

  typedef enum logic [3:0] {
    INIT       = 4'd0,
    WAIT_RJ    = 4'd1,
    READ_RJ    = 4'd2,
    WAIT_COEFF = 4'd3,
    READ_COEFF = 4'd4,
    WAIT_INPUT = 4'd5,
    WORKING    = 4'd6,
    CLEARING   = 4'd7,
    SLEEPING   = 4'd8
  } state_t;

  localparam int RJ_COUNT_DEF    = 16;
  localparam int COEFF_COUNT_DEF = 512;
  localparam int DATA_DEPTH_DEF  = 256;
  localparam int AW_DEF          = 10;

endpackage

// File: rtl/msdap_addr_counter.sv
// rtl/msdap_addr_counter.sv - address counter with sync clear, enable and wrap at max_val
module msdap_addr_counter #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic [AW-1:0] max_val,
  output logic [AW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == max_val) ? '0 : cnt + AW'(1);
    end
  end

endmodule

// File: rtl/msdap_main_ctrl.sv
// rtl/msdap_main_ctrl.sv - MSDAP top-level sequencer: memory sweeps, Rj/coeff load, data streaming
module msdap_main_ctrl
  import msdap_pkg::*;
#(
  parameter int RJ_COUNT    = RJ_COUNT_DEF,
  parameter int COEFF_COUNT = COEFF_COUNT_DEF,
  parameter int DATA_DEPTH  = DATA_DEPTH_DEF,
  parameter int AW          = AW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          frame_pulse,
  input  logic          word_valid,
  input  logic          data_zero,
  input  logic          all_zeros,
  input  logic          reset_req,
  input  logic          compute_busy,
  output logic [3:0]    state,
  output logic          in_ready,
  output logic          mem_clear_en,
  output logic [AW-1:0] clr_addr,
  output logic          rj_we,
  output logic          coeff_we,
  output logic          data_we,
  output logic [AW-1:0] wr_addr,
  output logic          compute_start,
  output logic          sleep,
  output logic          overrun
);

  localparam logic [AW-1:0] RJ_LAST    = AW'(RJ_COUNT - 1);
  localparam logic [AW-1:0] COEFF_LAST = AW'(COEFF_COUNT - 1);
  localparam logic [AW-1:0] DATA_LAST  = AW'(DATA_DEPTH - 1);

  state_t        state_q, state_d;
  logic          mem_clear_d;
  logic          sweep_done_q, sweep_done_d;
  logic          clr_last;
  logic          ptr_clr;
  logic [AW-1:0] ptr_max;

  assign state    = state_q;
  assign clr_last = mem_clear_en && (clr_addr == DATA_LAST);

  assign rj_we    = word_valid && (state_q == READ_RJ);
  assign coeff_we = word_valid && (state_q == READ_COEFF);
  // A pending soft reset beats a word arriving in the same cycle.
  assign data_we  = word_valid && !reset_req &&
                    ((state_q == WORKING) || ((state_q == SLEEPING) && !data_zero));

  assign ptr_clr = (state_q == CLEARING) ||
                   (frame_pulse && ((state_q == WAIT_RJ) || (state_q == WAIT_COEFF) ||
                                    (state_q == WAIT_INPUT)));

  // The shared pointer wraps at the last address of whichever memory is being filled,
  // so the final Rj/coeff write leaves it at zero for the next phase.
  always_comb begin
    case (state_q)
      READ_RJ:    ptr_max = RJ_LAST;
      READ_COEFF: ptr_max = COEFF_LAST;
      default:    ptr_max = DATA_LAST;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_clear_d  = 1'b0;
    sweep_done_d = 1'b0;
    case (state_q)
      INIT: begin
        mem_clear_d = !clr_last;
        if (clr_last) state_d = WAIT_RJ;
      end
      WAIT_RJ:    if (frame_pulse) state_d = READ_RJ;
      READ_RJ:    if (rj_we && wr_addr == RJ_LAST) state_d = WAIT_COEFF;
      WAIT_COEFF: if (frame_pulse) state_d = READ_COEFF;
      READ_COEFF: if (coeff_we && wr_addr == COEFF_LAST) state_d = WAIT_INPUT;
      WAIT_INPUT: begin
        if (reset_req)        state_d = CLEARING;
        else if (frame_pulse) state_d = WORKING;
      end
      WORKING: begin
        if (reset_req)      state_d = CLEARING;
        else if (all_zeros) state_d = SLEEPING;
      end
      SLEEPING: begin
        if (reset_req)    state_d = CLEARING;
        else if (data_we) state_d = WORKING;
      end
      CLEARING: begin
        mem_clear_d  = !sweep_done_q && !clr_last;
        sweep_done_d = sweep_done_q || clr_last;
        if (sweep_done_q && !reset_req) begin
          state_d      = WAIT_INPUT;
          sweep_done_d = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= INIT;
      mem_clear_en  <= 1'b0;
      sweep_done_q  <= 1'b0;
      in_ready      <= 1'b0;
      sleep         <= 1'b0;
      compute_start <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_clear_en  <= mem_clear_d;
      sweep_done_q  <= sweep_done_d;
      in_ready      <= (state_d != INIT) && (state_d != CLEARING);
      sleep         <= (state_d == SLEEPING);
      compute_start <= data_we;
      overrun       <= overrun || (data_we && compute_busy);
    end
  end

  msdap_addr_counter #(.AW(AW)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ptr_clr),
    .en      (rj_we || coeff_we || data_we),
    .max_val (ptr_max),
    .cnt     (wr_addr)
  );

  msdap_addr_counter #(.AW(AW)) u_clr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .en      (mem_clear_en),
    .max_val (DATA_LAST),
    .cnt     (clr_addr)
  );

endmodule

// File: tb/tb_msdap_main_ctrl.sv
// tb/tb_msdap_main_ctrl.sv - directed self-checking bench for msdap_main_ctrl
module tb_msdap_main_ctrl;

  localparam logic [3:0] S_INIT       = 4'd0;
  localparam logic [3:0] S_WAIT_RJ    = 4'd1;
  localparam logic [3:0] S_READ_RJ    = 4'd2;
  localparam logic [3:0] S_WAIT_COEFF = 4'd3;
  localparam logic [3:0] S_READ_COEFF = 4'd4;
  localparam logic [3:0] S_WAIT_INPUT = 4'd5;
  localparam logic [3:0] S_WORKING    = 4'd6;
  localparam logic [3:0] S_CLEARING   = 4'd7;
  localparam logic [3:0] S_SLEEPING   = 4'd8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_pulse = 1'b0;
  logic       word_valid = 1'b0;
  logic       data_zero = 1'b0;
  logic       all_zeros = 1'b0;
  logic       reset_req = 1'b0;
  logic       compute_busy = 1'b0;
  logic [3:0] state;
  logic       in_ready, mem_clear_en, rj_we, coeff_we, data_we;
  logic       compute_start, sleep, overrun;
  logic [9:0] clr_addr, wr_addr;

  int errors = 0;
  int checks = 0;
  int rj_writes = 0;
  int coeff_writes = 0;
  int data_writes = 0;

  always #5 clk = ~clk;

  msdap_main_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_pulse   (frame_pulse),
    .word_valid    (word_valid),
    .data_zero     (data_zero),
    .all_zeros     (all_zeros),
    .reset_req     (reset_req),
    .compute_busy  (compute_busy),
    .state         (state),
    .in_ready      (in_ready),
    .mem_clear_en  (mem_clear_en),
    .clr_addr      (clr_addr),
    .rj_we         (rj_we),
    .coeff_we      (coeff_we),
    .data_we       (data_we),
    .wr_addr       (wr_addr),
    .compute_start (compute_start),
    .sleep         (sleep),
    .overrun       (overrun)
  );

  always @(posedge clk) begin
    if (rj_we === 1'b1) rj_writes++;
    if (coeff_we === 1'b1) coeff_writes++;
    if (data_we === 1'b1) data_writes++;
  end

  task automatic next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    next();
    next();
    checks++;
    if ({state, in_ready, mem_clear_en, sleep, overrun, compute_start, rj_we, coeff_we, data_we} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b",
               {state, in_ready, mem_clear_en, sleep, overrun, compute_start, rj_we, coeff_we, data_we}, 12'h000);
    end
    checks++;
    if ({clr_addr, wr_addr} !== 20'd0) begin
      errors++;
      $display("FAIL reset_addrs got=%h want=0", {clr_addr, wr_addr});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      next();
      checks++;
      if (mem_clear_en !== 1'b1 || clr_addr !== 10'(i) || in_ready !== 1'b0 || state !== S_INIT) begin
        errors++;
        $display("FAIL init_sweep[%0d] got en=%b addr=%0d rdy=%b st=%0d want en=1 addr=%0d rdy=0 st=0",
                 i, mem_clear_en, clr_addr, in_ready, state, i);
      end
    end
    next();
    checks++;
    if ({state, in_ready, mem_clear_en} !== {S_WAIT_RJ, 1'b1, 1'b0} || clr_addr !== 10'd0) begin
      errors++;
      $display("FAIL init_done got st=%0d rdy=%b en=%b addr=%0d want st=1 rdy=1 en=0 addr=0",
               state, in_ready, mem_clear_en, clr_addr);
    end
  endtask

  task automatic test_rj_load();
    word_valid = 1'b1;
    #1;
    checks++;
    if (rj_we !== 1'b0) begin
      errors++;
      $display("FAIL rj_wait_ignores_word got=%b want=0", rj_we);
    end
    next();
    word_valid = 1'b0;
    frame_pulse = 1'b1;
    next();
    frame_pulse = 1'b0;
    checks++;
    if (state !== S_READ_RJ || wr_addr !== 10'd0) begin
      errors++;
      $display("FAIL rj_start got st=%0d addr=%0d want st=2 addr=0", state, wr_addr);
    end
    for (int i = 0; i < 16; i++) begin
      word_valid = 1'b1;
      #1;
      checks++;
      if ({rj_we, coeff_we, data_we} !== 3'b100 || wr_addr !== 10'(i)) begin
        errors++;
        $display("FAIL rj_write[%0d] got we=%b addr=%0d want we=100 addr=%0d",
                 i, {rj_we, coeff_we, data_we}, wr_addr, i);
      end
      next();
    end
    word_valid = 1'b0;
    checks++;
    if (state !== S_WAIT_COEFF || wr_addr !== 10'd0 || rj_writes !== 16) begin
      errors++;
      $display("FAIL rj_done got st=%0d addr=%0d writes=%0d want st=3 addr=0 writes=16",
               state, wr_addr, rj_writes);
    end
  endtask

  task automatic test_coeff_load();
    frame_pulse = 1'b1;
    next();
    frame_pulse = 1'b0;
    checks++;
    if (state !== S_READ_COEFF || wr_addr !== 10'd0) begin
      errors++;
      $display("FAIL coeff_start got st=%0d addr=%0d want st=4 addr=0", state, wr_addr);
    end
    for (int i = 0; i < 512; i++) begin
      word_valid = 1'b1;
      #1;
      checks++;
      if ({rj_we, coeff_we, data_we} !== 3'b010 || wr_addr !== 10'(i)) begin
        errors++;
        $display("FAIL coeff_write[%0d] got we=%b addr=%0d want we=010 addr=%0d",
                 i, {rj_we, coeff_we, data_we}, wr_addr, i);
      end
      next();
    end
    word_valid = 1'b0;
    checks++;
    if (state !== S_WAIT_INPUT || wr_addr !== 10'd0 || coeff_writes !== 512 || rj_writes !== 16) begin
      errors++;
      $display("FAIL coeff_done got st=%0d addr=%0d cw=%0d rw=%0d want st=5 addr=0 cw=512 rw=16",
               state, wr_addr, coeff_writes, rj_writes);
    end
    word_valid = 1'b1;
    #1;
    checks++;
    if ({rj_we, coeff_we, data_we} !== 3'b000) begin
      errors++;
      $display("FAIL wait_input_ignores_word got we=%b want=000", {rj_we, coeff_we, data_we});
    end
    next();
    word_valid = 1'b0;
  endtask

  task automatic test_working();
    frame_pulse = 1'b1;
    next();
    frame_pulse = 1'b0;
    checks++;
    if (state !== S_WORKING || wr_addr !== 10'd0) begin
      errors++;
      $display("FAIL working_start got st=%0d addr=%0d want st=6 addr=0", state, wr_addr);
    end
    for (int i = 0; i < 300; i++) begin
      word_valid = 1'b1;
      compute_busy = (i == 100);
      #1;
      checks++;
      if (data_we !== 1'b1 || wr_addr !== 10'(i % 256)) begin
        errors++;
        $display("FAIL data_write[%0d] got we=%b addr=%0d want we=1 addr=%0d", i, data_we, wr_addr, i % 256);
      end
      next();
      word_valid = 1'b0;
      compute_busy = (i == 50);
      checks++;
      if (compute_start !== 1'b1 || overrun !== (i >= 100)) begin
        errors++;
        $display("FAIL compute_start[%0d] got cs=%b ovr=%b want cs=1 ovr=%b", i, compute_start, overrun, i >= 100);
      end
      next();
      compute_busy = 1'b0;
      checks++;
      if (compute_start !== 1'b0) begin
        errors++;
        $display("FAIL compute_pulse_width[%0d] got=%b want=0", i, compute_start);
      end
    end
    checks++;
    if (data_writes !== 300 || wr_addr !== 10'd44 || state !== S_WORKING) begin
      errors++;
      $display("FAIL working_done got dw=%0d addr=%0d st=%0d want dw=300 addr=44 st=6", data_writes, wr_addr, state);
    end
  endtask

  task automatic test_sleep();
    word_valid = 1'b1;
    all_zeros = 1'b1;
    #1;
    checks++;
    if (data_we !== 1'b1 || wr_addr !== 10'd44) begin
      errors++;
      $display("FAIL write_with_all_zeros got we=%b addr=%0d want we=1 addr=44", data_we, wr_addr);
    end
    next();
    word_valid = 1'b0;
    all_zeros = 1'b0;
    checks++;
    if (state !== S_SLEEPING || sleep !== 1'b1 || wr_addr !== 10'd45) begin
      errors++;
      $display("FAIL enter_sleep got st=%0d sleep=%b addr=%0d want st=8 sleep=1 addr=45", state, sleep, wr_addr);
    end
    for (int k = 0; k < 3; k++) begin
      word_valid = 1'b1;
      data_zero = 1'b1;
      #1;
      checks++;
      if (data_we !== 1'b0) begin
        errors++;
        $display("FAIL sleep_zero_write[%0d] got=%b want=0", k, data_we);
      end
      next();
      word_valid = 1'b0;
      data_zero = 1'b0;
      checks++;
      if (compute_start !== 1'b0 || state !== S_SLEEPING || wr_addr !== 10'd45) begin
        errors++;
        $display("FAIL sleep_hold[%0d] got cs=%b st=%0d addr=%0d want cs=0 st=8 addr=45",
                 k, compute_start, state, wr_addr);
      end
    end
    word_valid = 1'b1;
    #1;
    checks++;
    if (data_we !== 1'b1 || wr_addr !== 10'd45) begin
      errors++;
      $display("FAIL wake_write got we=%b addr=%0d want we=1 addr=45", data_we, wr_addr);
    end
    next();
    word_valid = 1'b0;
    checks++;
    if (compute_start !== 1'b1 || state !== S_WORKING || sleep !== 1'b0 || wr_addr !== 10'd46) begin
      errors++;
      $display("FAIL wake got cs=%b st=%0d sleep=%b addr=%0d want cs=1 st=6 sleep=0 addr=46",
               compute_start, state, sleep, wr_addr);
    end
  endtask

  task automatic test_clearing();
    int n;
    word_valid = 1'b1;
    reset_req = 1'b1;
    #1;
    checks++;
    if (data_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_blocks_write got=%b want=0", data_we);
    end
    next();
    word_valid = 1'b0;
    checks++;
    if (state !== S_CLEARING || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL enter_clearing got st=%0d rdy=%b want st=7 rdy=0", state, in_ready);
    end
    n = 0;
    for (int k = 0; k < 300; k++) begin
      next();
      if (mem_clear_en === 1'b1) begin
        checks++;
        if (clr_addr !== 10'(n)) begin
          errors++;
          $display("FAIL clear_sweep[%0d] got addr=%0d want=%0d", n, clr_addr, n);
        end
        n++;
      end
    end
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL clear_sweep_len got=%0d want=256", n);
    end
    checks++;
    if (state !== S_CLEARING || mem_clear_en !== 1'b0 || wr_addr !== 10'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clearing_hold got st=%0d en=%b addr=%0d rdy=%b want st=7 en=0 addr=0 rdy=0",
               state, mem_clear_en, wr_addr, in_ready);
    end
    checks++;
    if (rj_writes !== 16 || coeff_writes !== 512 || data_writes !== 302) begin
      errors++;
      $display("FAIL retained_mems got rw=%0d cw=%0d dw=%0d want rw=16 cw=512 dw=302",
               rj_writes, coeff_writes, data_writes);
    end
    reset_req = 1'b0;
    next();
    checks++;
    if (state !== S_WAIT_INPUT || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL leave_clearing got st=%0d rdy=%b want st=5 rdy=1", state, in_ready);
    end
    frame_pulse = 1'b1;
    next();
    frame_pulse = 1'b0;
    word_valid = 1'b1;
    #1;
    checks++;
    if (state !== S_WORKING || data_we !== 1'b1 || wr_addr !== 10'd0) begin
      errors++;
      $display("FAIL restart_write got st=%0d we=%b addr=%0d want st=6 we=1 addr=0", state, data_we, wr_addr);
    end
    next();
    word_valid = 1'b0;
    checks++;
    if (compute_start !== 1'b1 || wr_addr !== 10'd1) begin
      errors++;
      $display("FAIL restart_next got cs=%b addr=%0d want cs=1 addr=1", compute_start, wr_addr);
    end
  endtask

  task automatic test_reset_mid_coeff();
    int k;
    reset_n = 1'b0;
    next();
    reset_n = 1'b1;
    k = 0;
    while (state !== S_WAIT_RJ && k < 400) begin
      next();
      k++;
    end
    checks++;
    if (state !== S_WAIT_RJ) begin
      errors++;
      $display("FAIL reboot_timeout got st=%0d want st=1", state);
    end
    frame_pulse = 1'b1;
    next();
    frame_pulse = 1'b0;
    word_valid = 1'b1;
    repeat (16) next();
    word_valid = 1'b0;
    next();
    frame_pulse = 1'b1;
    next();
    frame_pulse = 1'b0;
    word_valid = 1'b1;
    repeat (200) next();
    checks++;
    if (state !== S_READ_COEFF || wr_addr !== 10'd200 || coeff_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_coeff got st=%0d addr=%0d we=%b want st=4 addr=200 we=1", state, wr_addr, coeff_we);
    end
    reset_n = 1'b0;
    next();
    checks++;
    if ({state, in_ready, mem_clear_en, sleep, overrun, compute_start, rj_we, coeff_we, data_we} !== 12'h000 ||
        {clr_addr, wr_addr} !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid_coeff got st=%0d flags=%b clr=%0d wr=%0d want all 0",
               state, {in_ready, mem_clear_en, sleep, overrun, compute_start, rj_we, coeff_we, data_we},
               clr_addr, wr_addr);
    end
    word_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rj_load();
    test_coeff_load();
    test_working();
    test_sleep();
    test_clearing();
    test_reset_mid_coeff();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
